// File: rtl/seq_detector_param_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Width of the fill counter: it must hold every value 0..pat_w inclusive.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit-stream side of the detector: qualified serial input, pattern load and
// match outputs. There is no back-pressure. A bit is consumed on any rising
// edge where in_valid is high and load is low. A load edge takes priority and
// discards that cycle's bit.
interface seq_det_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) ();

    logic             in;
    logic             in_valid;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             out;
    logic [CNT_W-1:0] match_count;

    // Stream source / controller side
    modport master (
        output in, in_valid, load, pattern, overlap,
        input  out, match_count
    );

    // Detector side
    modport slave (
        input  in, in_valid, load, pattern, overlap,
        output out, match_count
    );

endinterface

// File: rtl/seq_detector_param_window.sv
// Shift window plus fill counter. Raises hit combinationally when the bit being
// consumed completes a full window equal to the latched pattern. The fill
// counter replaces the prefix-depth states of the old hand-coded Moore FSM.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,     // synchronous, active-low
    input  logic             clear_i,    // restart detection (pattern load)
    input  logic             valid_i,
    input  logic             bit_i,
    input  logic             overlap_i,
    input  logic [PAT_W-1:0] pat_i,
    output logic             hit_o
);

    localparam int             FW   = fill_w(PAT_W);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    logic [PAT_W-1:0] win_q, win_d, win_n;
    logic [FW-1:0]    fill_q, fill_d, fill_n;

    // Candidate window/fill for a consumed bit, the hit compare and next state.
    always_comb begin
        win_n  = {win_q[PAT_W-2:0], bit_i};
        fill_n = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hit_o  = valid_i && !clear_i && (fill_n == FULL) && (win_n == pat_i);
        win_d  = win_q;
        fill_d = fill_q;
        if (clear_i) begin
            win_d  = '0;
            fill_d = '0;
        end else if (valid_i) begin
            win_d = win_n;
            // Non-overlapping mode: the window contents remain, but a full
            // refill is needed before the next compare can succeed.
            fill_d = (hit_o && !overlap_i) ? '0 : fill_n;
        end
    end

    // Window and fill registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector. It holds the run-time pattern
// latch, the registered single-cycle match pulse and the saturating match
// counter. The window and compare logic sit in seq_det_window. The PAT_W and
// CNT_W parameters must match those of the connected interface instance.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,      // synchronous, active-low
    seq_det_if.slave   bus
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    seq_det_window #(.PAT_W(PAT_W)) u_window (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (bus.load),
        .valid_i   (bus.in_valid),
        .bit_i     (bus.in),
        .overlap_i (bus.overlap),
        .pat_i     (pat_q),
        .hit_o     (hit)
    );

    // Pattern latch, pulse and saturating count next state. Load wins over data.
    always_comb begin
        pat_d = pat_q;
        out_d = 1'b0;
        cnt_d = cnt_q;
        if (bus.load) begin
            pat_d = bus.pattern;
            cnt_d = '0;
        end else if (hit) begin
            out_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output and pattern registers. The pulse is never combinational from in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q <= '0;
            out_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param. Two instances share one
// stimulus: one uses CNT_W=8 and one uses CNT_W=2 to exercise saturation. A
// behavioural model keeps the history of consumed bits. It pushes the expected
// {out, count8, count2} for each driven cycle. The entry is popped and compared
// after the edge.
module tb_seq_detector_param;

    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset;
    logic t_in, t_valid, t_load, t_ovl;
    logic [PW-1:0] t_pat;

    always #5 clk = ~clk;

    seq_det_if #(.PAT_W(PW), .CNT_W(8)) bus_a ();
    seq_det_if #(.PAT_W(PW), .CNT_W(2)) bus_b ();

    assign bus_a.in       = t_in;
    assign bus_a.in_valid = t_valid;
    assign bus_a.load     = t_load;
    assign bus_a.pattern  = t_pat;
    assign bus_a.overlap  = t_ovl;
    assign bus_b.in       = t_in;
    assign bus_b.in_valid = t_valid;
    assign bus_b.load     = t_load;
    assign bus_b.pattern  = t_pat;
    assign bus_b.overlap  = t_ovl;

    seq_detector_param #(.PAT_W(PW), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seq_detector_param #(.PAT_W(PW), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Scoreboard and counters
    logic [10:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    // Reference model state
    logic [PW-1:0] m_pat = '0;
    bit            m_hist[$];
    int            m_cnt8 = 0;
    int            m_cnt2 = 0;

    logic [PW-1:0] cur_pat = 4'b1011;
    logic          cur_ovl = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Model one edge and return the expected {out, cnt8, cnt2}.
    function automatic logic [10:0] model(input logic rst_v, ld_v, vld_v, in_v,
                                          input logic [PW-1:0] pat_v, input logic ovl_v);
        logic hit = 1'b0;
        if (!rst_v) begin
            m_pat = '0;
            m_hist.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (ld_v) begin
            m_pat = pat_v;
            m_hist.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (vld_v) begin
            m_hist.push_back(in_v);
            if (m_hist.size() > PW) void'(m_hist.pop_front());
            if (m_hist.size() == PW) begin
                hit = 1'b1;
                for (int i = 0; i < PW; i++)
                    if (m_hist[i] != m_pat[PW-1-i]) hit = 1'b0;
            end
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!ovl_v) m_hist.delete();
            end
        end
        return {hit, m_cnt8[7:0], m_cnt2[1:0]};
    endfunction

    task automatic step(input logic rst_v, ld_v, vld_v, in_v,
                        input logic [PW-1:0] pat_v, input logic ovl_v);
        logic [10:0] e;
        reset   = rst_v;
        t_load  = ld_v;
        t_valid = vld_v;
        t_in    = in_v;
        t_pat   = pat_v;
        t_ovl   = ovl_v;
        exp_q.push_back(model(rst_v, ld_v, vld_v, in_v, pat_v, ovl_v));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("out_a", {31'd0, bus_a.out}, {31'd0, e[10]});
        chk("cnt_a", {24'd0, bus_a.match_count}, {24'd0, e[9:2]});
        chk("out_b", {31'd0, bus_b.out}, {31'd0, e[10]});
        chk("cnt_b", {30'd0, bus_b.match_count}, {30'd0, e[1:0]});
        pulse_cnt += int'(bus_a.out);
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            step(1'b1, 1'b0, 1'b1, bits[i], cur_pat, cur_ovl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), cur_pat, cur_ovl);
    endtask

    task automatic do_load(input logic [PW-1:0] p, input logic ovl);
        cur_pat = p;
        cur_ovl = ovl;
        // in_valid is high with random data during the load cycle; it must be ignored.
        step(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), p, ovl);
        pulse_cnt = 0;
    endtask

    initial begin
        // Reset held for two cycles with random valid data
        step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), cur_pat, cur_ovl);
        step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), cur_pat, cur_ovl);
        chk("rst_out", {31'd0, bus_a.out}, 32'd0);
        chk("rst_cnt", {24'd0, bus_a.match_count}, 32'd0);

        // Basic detection: a single pulse, on the cycle after the fourth bit
        do_load(4'b1011, 1'b1);
        send(32'b101, 3);
        chk("basic_early", {31'd0, bus_a.out}, 32'd0);
        send(32'b1, 1);
        chk("basic_pulse", {31'd0, bus_a.out}, 32'd1);
        chk("basic_total", pulse_cnt, 32'd1);

        // Overlapping detection
        do_load(4'b1011, 1'b1);
        send(32'b1011011, 7);
        chk("ovl_pulses", pulse_cnt, 32'd2);
        chk("ovl_cnt", {24'd0, bus_a.match_count}, 32'd2);

        // Non-overlapping detection
        do_load(4'b1011, 1'b0);
        send(32'b1011011, 7);
        chk("novl_pulses", pulse_cnt, 32'd1);
        chk("novl_cnt", {24'd0, bus_a.match_count}, 32'd1);

        // in_valid gaps keep a partial match
        do_load(4'b1011, 1'b1);
        send(32'b10, 2);
        idle(3);
        chk("gap_quiet", pulse_cnt, 32'd0);
        send(32'b11, 2);
        chk("gap_pulse", {31'd0, bus_a.out}, 32'd1);
        chk("gap_total", pulse_cnt, 32'd1);

        // A load after a partial match leaves no stale hit; 1111 then hits back-to-back
        do_load(4'b1011, 1'b1);
        send(32'b101, 3);
        do_load(4'b1111, 1'b1);
        send(32'b111, 3);
        chk("load_nostale", pulse_cnt, 32'd0);
        send(32'b1111, 4);
        chk("load_pulses", pulse_cnt, 32'd4);
        chk("load_cnt", {24'd0, bus_a.match_count}, 32'd4);

        // Saturation: five matches, with the 2-bit counter sticking at 3
        do_load(4'b1011, 1'b1);
        for (int k = 0; k < 5; k++) send(32'b1011, 4);
        chk("sat_pulses", pulse_cnt, 32'd5);
        chk("sat_cnt8", {24'd0, bus_a.match_count}, 32'd5);
        chk("sat_cnt2", {30'd0, bus_b.match_count}, 32'd3);

        // A reset in the middle of a match discards the partial match
        do_load(4'b1011, 1'b1);
        send(32'b101, 3);
        step(1'b0, 1'b0, 1'b1, 1'b1, cur_pat, cur_ovl);
        send(32'b1, 1);
        chk("rstmid_nopulse", pulse_cnt, 32'd0);
        do_load(4'b1011, 1'b1);
        send(32'b1011, 4);
        chk("rstmid_pulse", pulse_cnt, 32'd1);

        // Random stream with random valid and overlap. The pattern input changes
        // without a load; the model keeps the latched pattern.
        do_load(4'b1011, 1'b1);
        for (int k = 0; k < 300; k++) begin
            cur_ovl = 1'($urandom_range(0, 1));
            step(1'b1, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), cur_ovl);
        end

        // Random patterns, each with its own load, followed by random streams
        for (int r = 0; r < 6; r++) begin
            do_load(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 40; k++)
                step(1'b1, 1'b0, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                     cur_pat, cur_ovl);
        end

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
